pipelined_barrel_shifter: RTL
=============================

Name: pipelined_barrel_shifter

Overview:
- Parametrised, pipelined successor to the combinational right shifter.
- Supports 2**N-bit data and four operations: logical right, arithmetic right, logical left and rotate right.
- Has one register stage per shift-amount bit, with a valid/ready handshake on both sides.
- Sits between an operand source and a downstream consumer in datapath lab designs.

Parameters:
- N, 3, log2 of data width; shift amount width; pipeline depth. Legal range 1..6.
- W, 2**N, data width; derived localparam, not overridable.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous active-high reset
- in_valid  input  1  operand valid
- in_ready  output  1  shifter can accept this cycle
- num  input  W  operand
- shift  input  N  shift amount, 0..W-1
- op  input  2  operation, type shift_op_t
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- result  output  W  shifted operand

Behaviour:
- Reset (async, active-high): all stage valid bits, data, shift and op registers clear to 0; out_valid=0; result=0. in_ready is 1 once reset deasserts.
- Operation encoding (op):
  - 00 LSR: zero fill from the MSB side.
  - 01 ASR: fill with the original MSB.
  - 10 LSL: zero fill from the LSB side.
  - 11 ROR: bits leaving the LSB re-enter at the MSB.
- Stage structure:
  - Stage k (k=0..N-1) shifts its data by 2**k when bit k of the carried shift amount is set; otherwise it passes the data through.
  - Each stage registers its data, op, remaining shift bits and valid.
  - The ASR fill bit is the original operand MSB, carried down the pipeline. Do not use the intermediate MSB.
- Handshake and stall:
  - Advance enable: adv = ~out_valid | out_ready.
  - in_ready = adv, combinational.
  - A transfer occurs when in_valid & in_ready.
  - When adv=1, every stage loads from the stage before it, and stage 0 loads valid = in_valid & in_ready.
  - When adv=0, all stages hold their contents.
  - Stages holding bubbles (valid=0) still shift. Their data is don't-care, but it is deterministic.
- Latency and throughput:
  - Latency is exactly N cycles from the accept edge to out_valid=1 when there is no stall.
  - Throughput is one result per cycle.
- Output hold: result and out_valid stay stable while out_valid=1 and out_ready=0.
- Boundary conditions:
  - shift=0: result=num for every op.
  - shift=W-1 with LSR: result = {W-1 zeros, num[W-1]}.
  - Back-to-back transfers with alternating op values: each result uses its own op. There is no cross-talk between stages.
  - Reset mid-operation: all in-flight results are discarded, and out_valid drops asynchronously.
  - A stall of arbitrary length followed by release: no loss and no duplication of results.
- No X may propagate to result after reset, even when in_valid is X while in_ready=0 is being ignored by the source.

Optional Feature:
- Macro: SHIFTER_STICKY_EN.
- Defined:
  - Extra output port sticky (output, 1 bit), aligned with result.
  - For LSR and ASR, sticky is the OR of all bits shifted out past the LSB. For LSL and ROR, sticky=0.
  - sticky is accumulated per stage in the pipeline and resets to 0.
- Not defined: the port and its logic are absent. Port list and latency are otherwise identical.

Decomposition:
- Package shifter_pkg:
  - typedef enum logic [1:0] shift_op_t {OP_LSR, OP_ASR, OP_LSL, OP_ROR}.
  - Constant SHIFT_DEFAULT_N = 3.
- Sub-module shift_stage:
  - Parameters W, K. Combinational shift by 2**K for the given op and fill bit, with an enable input and a sticky output.
  - Instantiated N times with a generate loop. Registers stay in the top module.

Test Plan:
- N=3, num=8'b1101_0010, shift=3, run each op with out_ready=1 -> after 3 cycles:
  - LSR 0001_1010
  - ASR 1111_1010
  - LSL 1001_0000
  - ROR 0101_1010
- num=8'b1101_0010, shift=0, all four ops -> result 1101_0010 each, latency 3.
- Stream shift=1..7 with LSR on consecutive cycles -> results 0110_1001, 0011_0100, 0001_1010, 0000_1101, 0000_0110, 0000_0011, 0000_0001 in order, one per cycle.
- Same stream with out_ready=0 for 5 cycles mid-stream:
  - in_ready drops once the pipe is full.
  - result holds.
  - All 7 results arrive in order with no duplicates.
- Assert reset for 1 cycle while 3 operands are in flight -> out_valid=0 immediately and result=0. The next operand after release returns after exactly 3 cycles.
- With SHIFTER_STICKY_EN:
  - LSR 1101_0010 shift 3 -> sticky=1.
  - LSR shift 1 -> sticky=0.
  - ROR shift 3 -> sticky=0.

Source files
------------

// File: rtl/shifter_pkg.sv
// -----------------------------------------------------------------------------
// shifter_pkg
// Shared types and constants for the pipelined barrel shifter.
//   shift_op_t      : operation select carried alongside each operand
//   SHIFT_DEFAULT_N : default log2 of the data width (also the pipeline depth)
// -----------------------------------------------------------------------------
package shifter_pkg;

    typedef enum logic [1:0] {
        OP_LSR = 2'b00,   // logical right, zero fill at the MSB side
        OP_ASR = 2'b01,   // arithmetic right, fill with the original MSB
        OP_LSL = 2'b10,   // logical left, zero fill at the LSB side
        OP_ROR = 2'b11    // rotate right
    } shift_op_t;

    localparam int SHIFT_DEFAULT_N = 3;

endpackage

// File: rtl/shift_stage.sv
// -----------------------------------------------------------------------------
// shift_stage
// Combinational shift by a fixed distance of 2**K for one pipeline stage.
// Optional build macro: SHIFTER_STICKY_EN adds the sticky output.
// Parameters:
//   W : data width
//   K : stage index, shift distance is 2**K (must be below log2(W))
// Ports:
//   en       in   shift when 1, pass data through when 0
//   op       in   operation select
//   fill     in   fill bit for arithmetic right shift (original operand MSB)
//   data_in  in   data entering the stage
//   sticky   out  OR of bits dropped past the LSB (LSR/ASR only)
//   data_out out  shifted data
// -----------------------------------------------------------------------------
module shift_stage
    import shifter_pkg::*;
#(
    parameter int W = 8,
    parameter int K = 0
) (
    input  logic         en,
    input  shift_op_t    op,
    input  logic         fill,
    input  logic [W-1:0] data_in,
`ifdef SHIFTER_STICKY_EN
    output logic         sticky,
`endif
    output logic [W-1:0] data_out
);

    localparam int S = 1 << K;

    logic dropped;

    // NOTE: every output of a combinational block gets a default before the
    // case, otherwise an unassigned path infers a latch.
    always_comb begin
        data_out = data_in;
        dropped  = 1'b0;
        if (en) begin
            case (op)
                OP_LSR: begin
                    data_out = {{S{1'b0}}, data_in[W-1:S]};
                    dropped  = |data_in[S-1:0];
                end
                OP_ASR: begin
                    data_out = {{S{fill}}, data_in[W-1:S]};
                    dropped  = |data_in[S-1:0];
                end
                OP_LSL: data_out = {data_in[W-S-1:0], {S{1'b0}}};
                OP_ROR: data_out = {data_in[S-1:0], data_in[W-1:S]};
                default: ;
            endcase
        end
    end

`ifdef SHIFTER_STICKY_EN
    assign sticky = dropped;
`endif

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// -----------------------------------------------------------------------------
// pipelined_barrel_shifter
// N-stage pipelined barrel shifter on 2**N-bit data with valid/ready on both
// sides. Stage k conditionally shifts by 2**k using bit k of the shift amount.
// Whole pipe advances together: adv = ~out_valid | out_ready.
// Optional build macro: SHIFTER_STICKY_EN adds the sticky output.
// Parameters:
//   N : log2 of data width, shift width and pipeline depth (1..6)
//   W : data width, 2**N (derived)
// Ports:
//   clk       in   rising-edge clock
//   reset     in   asynchronous active-high reset
//   in_valid  in   operand valid
//   in_ready  out  shifter can accept this cycle
//   num       in   operand
//   shift     in   shift amount
//   op        in   operation select
//   out_valid out  result valid
//   out_ready in   consumer accepts result
//   sticky    out  OR of bits shifted out past the LSB (LSR/ASR), optional
//   result    out  shifted operand
// -----------------------------------------------------------------------------
module pipelined_barrel_shifter
    import shifter_pkg::*;
#(
    parameter  int N = SHIFT_DEFAULT_N,
    localparam int W = 1 << N
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] num,
    input  logic [N-1:0] shift,
    input  shift_op_t    op,
    output logic         out_valid,
    input  logic         out_ready,
`ifdef SHIFTER_STICKY_EN
    output logic         sticky,
`endif
    output logic [W-1:0] result
);

    logic adv;
    logic accept;

    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;
    assign accept   = in_valid & adv;

    for (genvar k = 0; k < N; k++) begin : g_stage
        // Shift bits still to be consumed at this stage; bit 0 drives this stage.
        localparam int R = N - k;

        logic [W-1:0] d_in;
        logic [W-1:0] d_out;
        logic [W-1:0] data_q;
        shift_op_t    op_in;
        logic [R-1:0] sh_in;
        logic         fill_in;
        logic         v_in;
        logic         valid_q;
`ifdef SHIFTER_STICKY_EN
        logic         stk_in;
        logic         stk_out;
        logic         sticky_q;
`endif

        if (k == 0) begin : g_head
            // Operands are gated by accept so bubbles carry zeros, never X.
            assign d_in    = accept ? num : '0;
            assign op_in   = accept ? op : OP_LSR;
            assign sh_in   = accept ? shift : '0;
            assign fill_in = accept & num[W-1];
            assign v_in    = accept;
`ifdef SHIFTER_STICKY_EN
            assign stk_in  = 1'b0;
`endif
        end else begin : g_link
            assign d_in    = g_stage[k-1].data_q;
            assign op_in   = g_stage[k-1].g_carry.op_q;
            assign sh_in   = g_stage[k-1].g_carry.sh_q;
            assign fill_in = g_stage[k-1].g_carry.fill_q;
            assign v_in    = g_stage[k-1].valid_q;
`ifdef SHIFTER_STICKY_EN
            assign stk_in  = g_stage[k-1].sticky_q;
`endif
        end

        shift_stage #(
            .W (W),
            .K (k)
        ) u_shift (
            .en       (sh_in[0]),
            .op       (op_in),
            .fill     (fill_in),
            .data_in  (d_in),
`ifdef SHIFTER_STICKY_EN
            .sticky   (stk_out),
`endif
            .data_out (d_out)
        );

        // NOTE: clocked state uses non-blocking assignments so every stage
        // samples the previous stage's pre-edge value.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                data_q  <= '0;
                valid_q <= 1'b0;
            end else if (adv) begin
                data_q  <= d_out;
                valid_q <= v_in;
            end
        end

`ifdef SHIFTER_STICKY_EN
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                sticky_q <= 1'b0;
            end else if (adv) begin
                sticky_q <= stk_in | stk_out;
            end
        end
`endif

        // Op, fill and remaining shift bits are only needed by later stages.
        if (k < N - 1) begin : g_carry
            shift_op_t    op_q;
            logic [R-2:0] sh_q;
            logic         fill_q;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    op_q   <= OP_LSR;
                    sh_q   <= '0;
                    fill_q <= 1'b0;
                end else if (adv) begin
                    op_q   <= op_in;
                    sh_q   <= sh_in[R-1:1];
                    fill_q <= fill_in;
                end
            end
        end
    end

    assign out_valid = g_stage[N-1].valid_q;
    assign result    = g_stage[N-1].data_q;
`ifdef SHIFTER_STICKY_EN
    assign sticky    = g_stage[N-1].sticky_q;
`endif

endmodule
